// File: rtl/serial_comparator_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package serial_comparator_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CMP  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic g;
    logic e;
    logic l;
  } cmp_res_t;

  function automatic int idx_w(input int width);
    return (width / SLICE_W > 1) ? $clog2(width / SLICE_W) : 1;
  endfunction

endpackage

// File: rtl/comparator_2bit.sv
// Combinational 2-bit unsigned magnitude comparator slice.
module comparator_2bit
  import serial_comparator_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic               g,
  output logic               e,
  output logic               l
);

  assign g = (a > b);
  assign e = (a == b);
  assign l = (a < b);

endmodule

// File: rtl/serial_comparator.sv
// MSB-first serial compare, one 2-bit slice per cycle, early exit on the first
// unequal slice. A start seen during the done cycle is taken as done falls.
module serial_comparator
  import serial_comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             e,
  output logic             l
);

  localparam int NSL   = WIDTH / SLICE_W;
  localparam int IDX_W = idx_w(WIDTH);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [SLICE_W-1:0] a_sl, b_sl;
  cmp_res_t           sl;

  assign a_sl = a_q[idx*SLICE_W +: SLICE_W];
  assign b_sl = b_q[idx*SLICE_W +: SLICE_W];

  comparator_2bit u_slice (
    .a (a_sl),
    .b (b_sl),
    .g (sl.g),
    .e (sl.e),
    .l (sl.l)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      g     <= 1'b0;
      e     <= 1'b0;
      l     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= IDX_W'(NSL - 1);
            g     <= 1'b0;
            e     <= 1'b0;
            l     <= 1'b0;
            busy  <= 1'b1;
            state <= S_CMP;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CMP: begin
          if (sl.g || sl.l) begin
            g     <= sl.g;
            l     <= sl.l;
            e     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (idx == '0) begin
            // all slices equal down to the LSB pair
            g     <= 1'b0;
            l     <= 1'b0;
            e     <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator: vector table plus multi-cycle corner sequences.
module tb_serial_comparator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, g, e, l;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  serial_comparator #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .g(g), .e(e), .l(l)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] gel;
    int         k;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Issue one compare from idle and check latency, busy length and result.
  task automatic run_cmp(input logic [7:0] va, input logic [7:0] vb,
                         input logic [2:0] gel, input int k, input string tag);
    int n;
    int busy_n;
    @(negedge clk);
    start = 1'b1; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; a = ~va; b = ~vb;
    n = 1; busy_n = 0;
    chk({tag, "_gel_during"}, int'({g, e, l}), 0);
    while (!done && n < 12) begin
      if (busy) busy_n++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, k + 1);
    chk({tag, "_busy_cycles"}, busy_n, k);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    chk({tag, "_gel"}, int'({g, e, l}), int'(gel));
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(done), 0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'hC0, 8'h40, 3'b100, 1};
    vecs[1] = '{8'h12, 8'h13, 3'b001, 4};
    vecs[2] = '{8'hFF, 8'h00, 3'b100, 1};
    vecs[3] = '{8'h00, 8'hFF, 3'b001, 1};
    vecs[4] = '{8'h30, 8'h20, 3'b100, 2};
    vecs[5] = '{8'h04, 8'h08, 3'b001, 3};
    vecs[6] = '{8'h00, 8'h00, 3'b010, 4};
    vecs[7] = '{8'hA5, 8'hA5, 3'b010, 4};

    #2;
    chk("reset_outs", int'({busy, done, g, e, l}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", int'({busy, done, g, e, l}), 0);

    foreach (vecs[i])
      run_cmp(vecs[i].a, vecs[i].b, vecs[i].gel, vecs[i].k, $sformatf("vec%0d", i));

    // equality result holds while idle
    repeat (10) @(negedge clk);
    chk("eq_hold_gel", int'({g, e, l}), 3'b010);
    chk("eq_hold_done", int'(done), 0);

    // async reset between edges
    #2 rst_n = 1'b0;
    #1 chk("async_reset", int'({busy, done, g, e, l}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // start held high; inputs changed mid-compare
    begin
      int n;
      @(negedge clk);
      start = 1'b1; a = 8'h01; b = 8'h02;
      @(negedge clk);
      a = 8'hFF; b = 8'h00;
      n = 1;
      while (!done && n < 12) begin @(negedge clk); n++; end
      chk("hold_latency", n, 5);
      chk("hold_gel", int'({g, e, l}), 3'b001);
      @(negedge clk);
      chk("hold_reaccept_busy", int'({busy, done}), 2'b10);
      chk("hold_reaccept_gel", int'({g, e, l}), 0);
      @(negedge clk);
      chk("hold_second_done", int'(done), 1);
      chk("hold_second_gel", int'({g, e, l}), 3'b100);
      start = 1'b0;
      @(negedge clk);
    end

    // reset in the middle of a compare
    begin
      int seen;
      @(negedge clk);
      start = 1'b1; a = 8'h00; b = 8'h00;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk("midop_reset", int'({busy, done, g, e, l}), 0);
      seen = 0;
      repeat (3) begin @(negedge clk); if (done) seen++; end
      rst_n = 1'b1;
      repeat (6) begin @(negedge clk); if (done || busy) seen++; end
      chk("midop_no_done", seen, 0);
    end
    run_cmp(8'hFF, 8'h00, 3'b100, 1, "post_reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
